// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port synchronous memory: fair tie-break on
// last_served, bounded bursts while the other master waits, registered read-valid.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int BURST_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req,
    input  logic [15:0] m0_addr,
    input  logic [7:0]  m0_wdata,
    input  logic        m0_we,
    output logic        m0_gnt,
    output logic [7:0]  m0_rdata,
    output logic        m0_rvalid,

    input  logic        m1_req,
    input  logic [15:0] m1_addr,
    input  logic [7:0]  m1_wdata,
    input  logic        m1_we,
    output logic        m1_gnt,
    output logic [7:0]  m1_rdata,
    output logic        m1_rvalid,

    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);

    state_t     state_q, state_d;
    logic       last_served_q, last_served_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       m0_rvalid_q, m0_rvalid_d;
    logic       m1_rvalid_q, m1_rvalid_d;

    // Grants follow the live request of the current owner; state reset clears them.
    always_comb begin
        m0_gnt = (state_q == OWN0) && m0_req;
        m1_gnt = (state_q == OWN1) && m1_req;
    end

    always_comb begin
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        if (m0_gnt) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_we    = m0_we;
        end else if (m1_gnt) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_we    = m1_we;
        end
    end

    always_comb begin
        m0_rvalid = m0_rvalid_q;
        m1_rvalid = m1_rvalid_q;
        m0_rdata  = m0_rvalid_q ? mem_rdata : 8'h00;
        m1_rdata  = m1_rvalid_q ? mem_rdata : 8'h00;
    end

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        burst_cnt_d   = burst_cnt_q;
        m0_rvalid_d   = m0_gnt && !m0_we;
        m1_rvalid_d   = m1_gnt && !m1_we;

        case (state_q)
            IDLE: begin
                burst_cnt_d = 8'd0;
                if (m0_req && m1_req) begin
                    state_d = last_served_q ? OWN0 : OWN1;
                end else if (m0_req) begin
                    state_d = OWN0;
                end else if (m1_req) begin
                    state_d = OWN1;
                end
            end

            OWN0: begin
                if (!m0_req) begin
                    burst_cnt_d = 8'd0;
                    state_d     = m1_req ? OWN1 : IDLE;
                end else begin
                    last_served_d = 1'b0;
                    if (m1_req && (burst_cnt_q == BURST_LAST)) begin
                        burst_cnt_d = 8'd0;
                        state_d     = OWN1;
                    end else if (burst_cnt_q != BURST_LAST) begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end
                end
            end

            OWN1: begin
                if (!m1_req) begin
                    burst_cnt_d = 8'd0;
                    state_d     = m0_req ? OWN0 : IDLE;
                end else begin
                    last_served_d = 1'b1;
                    if (m0_req && (burst_cnt_q == BURST_LAST)) begin
                        burst_cnt_d = 8'd0;
                        state_d     = OWN0;
                    end else if (burst_cnt_q != BURST_LAST) begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d     = IDLE;
                burst_cnt_d = 8'd0;
            end
        endcase
    end

    // last_served resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
            burst_cnt_q   <= 8'd0;
            m0_rvalid_q   <= 1'b0;
            m1_rvalid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            burst_cnt_q   <= burst_cnt_d;
            m0_rvalid_q   <= m0_rvalid_d;
            m1_rvalid_q   <= m1_rvalid_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural synchronous memory, read-data
// scoreboard per master, and per-cycle port invariants.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int BURST_MAX = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [15:0] m0_addr = 16'h0, m1_addr = 16'h0;
    logic [7:0]  m0_wdata = 8'h0, m1_wdata = 8'h0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
    logic [7:0]  m0_rdata, m1_rdata, mem_wdata;
    logic [7:0]  mem_rdata = 8'h0;
    logic [15:0] mem_addr;

    int checks = 0;
    int errors = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       exp_rv0 = 1'b0;
    logic       exp_rv1 = 1'b0;
    logic [7:0] ref_mem [int];
    logic [7:0] mem_array [int];

    mem_arbiter #(.BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Synchronous memory, read-before-write, unwritten bytes follow init_byte.
    always @(posedge clk) begin
        logic [7:0] rd;
        rd = mem_array.exists(int'(mem_addr)) ? mem_array[int'(mem_addr)] : init_byte(mem_addr);
        if (mem_we) mem_array[int'(mem_addr)] = mem_wdata;
        mem_rdata <= rd;
    end

    function automatic logic [7:0] ref_byte(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_byte(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic mon_step();
        logic [15:0] ea;
        logic [7:0]  ew;
        logic        ewe;
        if (rst_n !== 1'b1) begin
            exp_rv0 = 1'b0;
            exp_rv1 = 1'b0;
            q0.delete();
            q1.delete();
            return;
        end
        ea  = m0_gnt ? m0_addr  : (m1_gnt ? m1_addr  : 16'h0);
        ew  = m0_gnt ? m0_wdata : (m1_gnt ? m1_wdata : 8'h0);
        ewe = (m0_gnt & m0_we) | (m1_gnt & m1_we);
        chk("gnt_excl", 32'(m0_gnt & m1_gnt), 0);
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        chk("mem_wdata", 32'(mem_wdata), 32'(ew));
        chk("mem_we", 32'(mem_we), 32'(ewe));
        chk("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv0));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv1));
        if (m0_rvalid === 1'b1 && q0.size() > 0) chk("m0_rdata", 32'(m0_rdata), 32'(q0.pop_front()));
        else if (m0_rvalid !== 1'b1) chk("m0_rdata_zero", 32'(m0_rdata), 0);
        if (m1_rvalid === 1'b1 && q1.size() > 0) chk("m1_rdata", 32'(m1_rdata), 32'(q1.pop_front()));
        else if (m1_rvalid !== 1'b1) chk("m1_rdata_zero", 32'(m1_rdata), 0);
        exp_rv0 = m0_gnt & ~m0_we;
        exp_rv1 = m1_gnt & ~m1_we;
        if (m0_gnt === 1'b1) begin
            if (m0_we) ref_mem[int'(m0_addr)] = m0_wdata;
            else q0.push_back(ref_byte(m0_addr));
        end
        if (m1_gnt === 1'b1) begin
            if (m1_we) ref_mem[int'(m1_addr)] = m1_wdata;
            else q1.push_back(ref_byte(m1_addr));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int m, input int bound, output int cyc);
        cyc = 0;
        @(negedge clk);
        while (((m == 0) ? m0_gnt : m1_gnt) !== 1'b1 && cyc < bound) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int cnt;
        logic e0;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        // Reset state, with both masters already requesting.
        m0_req = 1'b1; m0_addr = 16'h0010;
        m1_req = 1'b1; m1_addr = 16'h0020;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_gnt", 32'(m0_gnt), 0);
        chk("rst_m1_gnt", 32'(m1_gnt), 0);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);

        // Both held from reset: 8 to m0, 8 to m1 back to back, then m0 again.
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            e0 = (i >= 1) && (((i - 1) / BURST_MAX) % 2 == 0);
            chk($sformatf("burst_m0_c%0d", i), 32'(m0_gnt), 32'(e0));
            chk($sformatf("burst_m1_c%0d", i), 32'(m1_gnt), 32'((i >= 1) && !e0));
        end
        step();
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) step();

        // m0 single read of 0x1234 from IDLE.
        m0_addr = 16'h1234; m0_we = 1'b0; m0_req = 1'b1;
        wait_gnt(0, 20, cyc);
        chk("rd1234_latency", 32'(cyc), 1);
        chk("rd1234_mem_addr", 32'(mem_addr), 32'h1234);
        step();
        m0_req = 1'b0;
        @(negedge clk);
        chk("rd1234_rvalid", 32'(m0_rvalid), 1);
        chk("rd1234_rdata", 32'(m0_rdata), 32'h1A);
        repeat (2) step();

        // m1 writes 0xA5 to 0x0100, m0 reads it back.
        m1_addr = 16'h0100; m1_wdata = 8'hA5; m1_we = 1'b1; m1_req = 1'b1;
        wait_gnt(1, 20, cyc);
        chk("wr_latency", 32'(cyc), 1);
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
        step();
        m1_req = 1'b0; m1_we = 1'b0;
        repeat (2) step();
        m0_addr = 16'h0100; m0_req = 1'b1;
        wait_gnt(0, 20, cyc);
        step();
        m0_req = 1'b0;
        @(negedge clk);
        chk("rdback_rvalid", 32'(m0_rvalid), 1);
        chk("rdback_rdata", 32'(m0_rdata), 32'hA5);
        repeat (2) step();

        // m0 releases while m1 waits: one idle cycle, then m1.
        m0_addr = 16'h0300; m0_req = 1'b1;
        wait_gnt(0, 20, cyc);
        step();
        m0_req = 1'b0;
        m1_addr = 16'h0400; m1_req = 1'b1;
        @(negedge clk);
        chk("release_gap_m0", 32'(m0_gnt), 0);
        chk("release_gap_m1", 32'(m1_gnt), 0);
        @(negedge clk);
        chk("release_m1_gnt", 32'(m1_gnt), 1);
        step();
        m1_req = 1'b0;
        repeat (3) step();

        // m0 alone for 300 grants, then m1 must get in at the burst limit.
        m0_addr = 16'h0200; m0_req = 1'b1;
        wait_gnt(0, 20, cyc);
        cnt = (m0_gnt === 1'b1) ? 1 : 0;
        for (int k = 1; k < 300; k++) begin
            @(negedge clk);
            if (m0_gnt === 1'b1) cnt++;
        end
        chk("long_grants", 32'(cnt), 300);
        step();
        m1_addr = 16'h0500; m1_req = 1'b1;
        wait_gnt(1, 300, cyc);
        chk("long_m1_latency", 32'(cyc), 1);
        chk("long_m0_off", 32'(m0_gnt), 0);
        step();
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) step();

        // Reset during an m1 read grant.
        m1_addr = 16'h0600; m1_req = 1'b1;
        wait_gnt(1, 20, cyc);
        chk("rstmid_pre_gnt", 32'(m1_gnt), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_m1_gnt", 32'(m1_gnt), 0);
        chk("rstmid_m0_gnt", 32'(m0_gnt), 0);
        chk("rstmid_mem_we", 32'(mem_we), 0);
        chk("rstmid_mem_addr", 32'(mem_addr), 0);
        m1_req = 1'b0;
        @(posedge clk);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_m1_rvalid_a", 32'(m1_rvalid), 0);
        @(negedge clk);
        chk("rstmid_m1_rvalid_b", 32'(m1_rvalid), 0);

        repeat (4) step();
        chk("q0_drained", 32'(q0.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 8: max consecutive grants to one master while the other is requesting; legal range 1..255.
REQ-002 clock  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 m0_req  input  1  master 0 (core data port) transfer request.
REQ-005 m0_addr  input  16  master 0 byte address.
REQ-006 m0_wdata  input  8  master 0 write data.
REQ-007 m0_we  input  1  master 0 write enable (1 = write, 0 = read).
REQ-008 m0_gnt  output  1  master 0 transfer accepted this cycle.
REQ-009 m0_rdata  output  8  master 0 read data.
REQ-010 m0_rvalid  output  1  m0_rdata valid.
REQ-011 m1_req, m1_addr, m1_wdata, m1_we, m1_gnt, m1_rdata, m1_rvalid  same directions, widths and meanings as m0_*, for master 1 (UART program loader).
REQ-012 mem_addr  output  16  shared memory data-port address.
REQ-013 mem_wdata  output  8  shared memory write data.
REQ-014 mem_we  output  1  shared memory write strobe.
REQ-015 mem_rdata  input  8  shared memory read data; synchronous, valid the cycle after the address.

Function
REQ-016 FSM states IDLE, OWN0, OWN1; a registered owner; a registered last_served flag; an 8-bit burst counter.
REQ-017 IDLE: no req -> stay IDLE; one req -> that master's OWN state; both -> OWN of the master not equal to last_served.
REQ-018 Arbitration latency: a req first seen in IDLE at cycle N yields gnt at cycle N+1.
REQ-019 OWNx: mx_gnt = mx_req, combinational; other master's gnt = 0.
REQ-020 Each cycle with mx_gnt = 1 is exactly one transfer; burst counter increments; last_served <= x.
REQ-021 OWNx, mx_req = 0: other req = 1 -> OWN of the other master, counter cleared; else -> IDLE, counter cleared.
REQ-022 OWNx, mx_req = 1, other req = 1, counter = BURST_MAX-1 with a grant this cycle -> switch to other OWN next cycle, counter cleared.
REQ-023 OWNx, mx_req = 1, other req = 0: keep ownership indefinitely; counter saturates at BURST_MAX-1 and does not wrap.
REQ-024 Memory port muxed from owner while its gnt = 1; otherwise mem_addr = 0, mem_wdata = 0, mem_we = 0.
REQ-025 mem_we = mx_we & mx_gnt; write takes effect in the grant cycle.
REQ-026 mx_rvalid registered: 1 in the cycle after mx_gnt & ~mx_we, else 0.
REQ-027 mx_rdata = mem_rdata when mx_rvalid = 1, else 0.
REQ-028 Masters hold req, addr, wdata and we stable until gnt; back-to-back transfers are allowed by holding req high.
REQ-029 Never both gnts high in one cycle; mem_we never high without a gnt.
REQ-030 Ownership switch between two requesting masters costs no idle cycle on a burst-limit switch, and exactly one idle cycle on a release switch (REQ-021).

Reset
REQ-031 reset low asynchronously forces: state IDLE, counter 0, last_served = 1 (master 0 wins the first tie), both gnt = 0, both rvalid = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-032 Reset asserted mid-burst discards the in-flight grant; a pending rvalid does not appear after reset release.
REQ-033 After reset deasserts, the first arbitration occurs on the first rising edge with reset high.

Verification
REQ-034 m0 read 0x1234 alone from IDLE -> m0_gnt at cycle 1, mem_addr = 0x1234, m0_rvalid at cycle 2 with m0_rdata = memory byte.
REQ-035 Both req from reset (BURST_MAX = 8), both held -> m0 gets 8 grants, m1 gets 8 with no gap, then m0 again; gnts never overlap.
REQ-036 m1 writes 0xA5 to 0x0100 while m0 idle, then m0 reads 0x0100 -> m0_rdata = 0xA5.
REQ-037 m0 holds req 300 cycles alone -> 300 consecutive grants, no counter wrap; m1 then requests -> m1 granted within BURST_MAX cycles.
REQ-038 Reset pulled low in the cycle of an m1 read grant -> mem_we = 0 and both gnt = 0 immediately; m1_rvalid = 0 after release.
REQ-039 m0 drops req in OWN0 while m1 requests -> one cycle with both gnt = 0, then m1_gnt = 1.
